// File: rtl/ahbl_master_arbiter.sv
// Round-robin AHB-Lite bus arbiter for up to four masters. It never breaks a fixed-length
// burst or a locked sequence, parks the bus on master 0, and pipelines address and data ownership.
module ahbl_master_arbiter #(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [1:0]             HMASTER,
  output logic                   HMASTLOCK,
  output logic [1:0]             HMASTER_D
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr   = 3'b001;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [1:0]             grant_idx_q, grant_idx_d;
  logic [1:0]             hmaster_q, hmaster_d;
  logic [1:0]             hmaster_dp_q, hmaster_dp_d;
  logic                   mastlock_q, mastlock_d;
  logic [4:0]             cnt_q, cnt_d;

  logic [3:0] req_ext, lock_ext, grant_oh;
  logic [4:0] len_m1;
  logic       burst_incr;
  logic       switch_ok;
  logic       found;
  logic [1:0] next_idx;

  // Widen to four so that any 2-bit index stays inside the vector; absent masters read as 0.
  assign req_ext  = 4'(HBUSREQ);
  assign lock_ext = 4'(HLOCK);

  always_comb begin
    len_m1     = 5'd0;
    burst_incr = 1'b0;
    case (HBURST)
      3'b000:          len_m1 = 5'd0;
      3'b001:          burst_incr = 1'b1;
      3'b010, 3'b011:  len_m1 = 5'd3;
      3'b100, 3'b101:  len_m1 = 5'd7;
      default:         len_m1 = 5'd15;
    endcase
  end

  always_comb begin
    switch_ok = 1'b0;
    case (HTRANS)
      TransIdle:   switch_ok = 1'b1;
      TransNonseq: switch_ok = (HBURST == BurstSingle) || (HBURST == BurstIncr);
      TransSeq:    switch_ok = (cnt_q == 5'd1) || burst_incr;
      default:     switch_ok = 1'b0;
    endcase
    if (lock_ext[grant_idx_q]) switch_ok = 1'b0;
  end

  // Cyclic search starting one past the current owner; the current owner is tried last.
  always_comb begin
    found    = 1'b0;
    next_idx = 2'd0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      int unsigned c;
      c = (32'(grant_idx_q) + k) % NUM_MASTERS;
      if (!found && req_ext[2'(c)]) begin
        found    = 1'b1;
        next_idx = 2'(c);
      end
    end
  end

  always_comb begin
    grant_idx_d  = grant_idx_q;
    cnt_d        = cnt_q;
    hmaster_d    = hmaster_q;
    hmaster_dp_d = hmaster_dp_q;
    mastlock_d   = mastlock_q;
    if (HREADY) begin
      if (HTRANS == TransNonseq) begin
        cnt_d = len_m1;
      end else if (HTRANS == TransSeq && cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end
      if (switch_ok) grant_idx_d = found ? next_idx : 2'd0;
      hmaster_d    = grant_idx_q;
      mastlock_d   = lock_ext[grant_idx_q];
      hmaster_dp_d = hmaster_q;
    end
    grant_oh = 4'b0001 << grant_idx_d;
    grant_d  = grant_oh[NUM_MASTERS-1:0];
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      grant_q      <= NUM_MASTERS'(1);
      grant_idx_q  <= 2'd0;
      hmaster_q    <= 2'd0;
      hmaster_dp_q <= 2'd0;
      mastlock_q   <= 1'b0;
      cnt_q        <= 5'd0;
    end else begin
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      mastlock_q   <= mastlock_d;
      cnt_q        <= cnt_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;
  assign HMASTER_D = hmaster_dp_q;

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed self-checking bench for ahbl_master_arbiter with two masters.
module tb_ahbl_master_arbiter;

  localparam logic [1:0] Idle   = 2'b00;
  localparam logic [1:0] Busy   = 2'b01;
  localparam logic [1:0] Nonseq = 2'b10;
  localparam logic [1:0] Seq    = 2'b11;
  localparam logic [2:0] Single = 3'b000;
  localparam logic [2:0] Incr4  = 3'b011;
  localparam logic [2:0] Wrap8  = 3'b100;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [1:0] hbusreq, hlock, htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hgrant, hmaster, hmaster_dp;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  ahbl_master_arbiter #(.NUM_MASTERS(2)) dut (
    .HCLK      (hclk),
    .HRESETN   (hresetn),
    .HBUSREQ   (hbusreq),
    .HLOCK     (hlock),
    .HTRANS    (htrans),
    .HBURST    (hburst),
    .HREADY    (hready),
    .HGRANT    (hgrant),
    .HMASTER   (hmaster),
    .HMASTLOCK (hmastlock),
    .HMASTER_D (hmaster_dp)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] g, input logic [1:0] m,
                            input logic [1:0] md, input logic ml);
    check({tag, ".grant"}, 8'(hgrant), 8'(g));
    check({tag, ".hmaster"}, 8'(hmaster), 8'(m));
    check({tag, ".hmaster_d"}, 8'(hmaster_dp), 8'(md));
    check({tag, ".mastlock"}, 8'(hmastlock), 8'(ml));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic [1:0] req, input logic [1:0] lck, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0;
    hbusreq = 2'b11;
    hlock   = 2'b00;
    htrans  = Idle;
    hburst  = Single;
    hready  = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    expect_out("reset", 2'b01, 2'd0, 2'd0, 1'b0);
    hresetn = 1'b1;
    cyc(2'b11, 2'b00, Idle, Single, 1'b1);
    expect_out("rel", 2'b10, 2'd0, 2'd0, 1'b0);

    // Alternating singles
    cyc(2'b11, 2'b00, Nonseq, Single, 1'b1);
    expect_out("alt0", 2'b01, 2'd1, 2'd0, 1'b0);
    cyc(2'b11, 2'b00, Nonseq, Single, 1'b1);
    expect_out("alt1", 2'b10, 2'd0, 2'd1, 1'b0);
    cyc(2'b11, 2'b00, Nonseq, Single, 1'b1);
    expect_out("alt2", 2'b01, 2'd1, 2'd0, 1'b0);

    // Master 1 takes the bus, then runs INCR4 while master 0 requests
    cyc(2'b10, 2'b00, Idle, Single, 1'b1);
    expect_out("own1a", 2'b10, 2'd0, 2'd1, 1'b0);
    cyc(2'b10, 2'b00, Idle, Single, 1'b1);
    expect_out("own1b", 2'b10, 2'd1, 2'd0, 1'b0);
    cyc(2'b11, 2'b00, Nonseq, Incr4, 1'b1);
    expect_out("incr4_b1", 2'b10, 2'd1, 2'd1, 1'b0);
    cyc(2'b11, 2'b00, Seq, Incr4, 1'b1);
    expect_out("incr4_b2", 2'b10, 2'd1, 2'd1, 1'b0);
    cyc(2'b11, 2'b00, Seq, Incr4, 1'b1);
    expect_out("incr4_b3", 2'b10, 2'd1, 2'd1, 1'b0);
    cyc(2'b11, 2'b00, Seq, Incr4, 1'b1);
    expect_out("incr4_b4", 2'b01, 2'd1, 2'd1, 1'b0);

    // Locked sequence by master 0
    cyc(2'b11, 2'b01, Nonseq, Single, 1'b1);
    expect_out("lock0", 2'b01, 2'd0, 2'd1, 1'b1);
    for (int i = 1; i < 5; i++) begin
      cyc(2'b11, 2'b01, Nonseq, Single, 1'b1);
      expect_out($sformatf("lock%0d", i), 2'b01, 2'd0, 2'd0, 1'b1);
    end
    cyc(2'b11, 2'b00, Nonseq, Single, 1'b1);
    expect_out("unlock", 2'b10, 2'd0, 2'd0, 1'b0);

    // Wait states freeze everything while requests move
    cyc(2'b01, 2'b00, Idle, Single, 1'b0);
    expect_out("wait0", 2'b10, 2'd0, 2'd0, 1'b0);
    cyc(2'b00, 2'b00, Idle, Single, 1'b0);
    expect_out("wait1", 2'b10, 2'd0, 2'd0, 1'b0);
    cyc(2'b11, 2'b00, Idle, Single, 1'b0);
    expect_out("wait2", 2'b10, 2'd0, 2'd0, 1'b0);
    cyc(2'b01, 2'b00, Idle, Single, 1'b1);
    expect_out("resume", 2'b01, 2'd1, 2'd0, 1'b0);

    // Reset in the middle of a WRAP8 owned by master 1
    cyc(2'b10, 2'b00, Idle, Single, 1'b1);
    expect_out("w8own_a", 2'b10, 2'd0, 2'd1, 1'b0);
    cyc(2'b10, 2'b00, Idle, Single, 1'b1);
    expect_out("w8own_b", 2'b10, 2'd1, 2'd0, 1'b0);
    cyc(2'b10, 2'b00, Nonseq, Wrap8, 1'b1);
    expect_out("w8_b1", 2'b10, 2'd1, 2'd1, 1'b0);
    htrans = Seq;
    #3;
    hresetn = 1'b0;
    #1;
    expect_out("w8_rst", 2'b01, 2'd0, 2'd0, 1'b0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    cyc(2'b00, 2'b00, Idle, Single, 1'b1);
    expect_out("park", 2'b01, 2'd0, 2'd0, 1'b0);
    cyc(2'b10, 2'b00, Seq, Incr4, 1'b1);
    expect_out("seq_cnt0", 2'b01, 2'd0, 2'd0, 1'b0);
    cyc(2'b11, 2'b00, Busy, Single, 1'b1);
    expect_out("busy", 2'b01, 2'd0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
